// File: rtl/paddle_input_conditioner_if.sv
// Bundle of the raw pad inputs and the conditioned per-channel outputs
// of the paddle input conditioner. The conditioner sits on the slave side;
// whoever drives the raw pads and consumes the clean events is the master.
interface paddle_input_conditioner_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_repeat;
    logic            sample_tick;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat,
        input  sample_tick
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat,
        output sample_tick
    );
endinterface

// File: rtl/paddle_input_conditioner.sv
// Paddle input conditioner: synchronises the asynchronous pong controls,
// debounces them on a slow shared sample tick and produces per channel a
// clean level, press/release pulses and optional auto-repeat pulses.
// Every output is a flop; events appear the cycle after the deciding tick.
module paddle_input_conditioner #(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = 65536,
    parameter int DB_COUNT     = 16,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_DELAY = 40,
    parameter int REPEAT_RATE  = 8
) (
    input  logic ClkPort,
    input  logic Reset_n,
    paddle_input_conditioner_if.slave bus
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = $clog2(DB_COUNT + 1);
    localparam int RPT_W  = $clog2(REPEAT_DELAY + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DB_COUNT);
    localparam logic [RPT_W-1:0]  RPT_ZERO   = RPT_W'(0);
    localparam logic [RPT_W-1:0]  RPT_ONE    = RPT_W'(1);
    localparam logic [RPT_W-1:0]  RPT_FIRE   = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0]  RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

    // LOW/PEND_HI report level 0, HIGH/PEND_LO report level 1.
    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_PEND_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_PEND_LO = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Synchroniser chain (only the last stage feeds the debouncers)
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_d [SYNC_STAGES];
    logic [N_CH-1:0] s_s;

    // Shift the raw pads one stage deeper every clock.
    always_comb begin
        sync_d[0] = bus.btn_raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops, cleared on reset.
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {N_CH{1'b0}};
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign s_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Shared sample-tick prescaler
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              tick_s;
    logic              sample_tick_q;
    logic              sample_tick_d;

    // Count 0..TICK_DIV-1 and flag the last count as the sample tick.
    always_comb begin
        tick_s        = (tick_cnt_q == TICK_LAST);
        sample_tick_d = tick_s;
        if (tick_s) begin
            tick_cnt_d = {TICK_W{1'b0}};
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
        end
    end

    // Prescaler counter and registered tick output.
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt_q    <= {TICK_W{1'b0}};
            sample_tick_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            sample_tick_q <= sample_tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce FSM with auto-repeat
    // ------------------------------------------------------------------
    state_e          state_q [N_CH];
    state_e          state_d [N_CH];
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [RPT_W-1:0] rpt_q  [N_CH];
    logic [RPT_W-1:0] rpt_d  [N_CH];

    logic [N_CH-1:0] level_q;
    logic [N_CH-1:0] level_d;
    logic [N_CH-1:0] press_q;
    logic [N_CH-1:0] press_d;
    logic [N_CH-1:0] release_q;
    logic [N_CH-1:0] release_d;
    logic [N_CH-1:0] repeat_q;
    logic [N_CH-1:0] repeat_d;

    // State register: FSM state, sample counters, repeat counters, outputs.
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= ST_LOW;
                cnt_q[ch]   <= CNT_ZERO;
                rpt_q[ch]   <= RPT_ZERO;
            end
            level_q   <= {N_CH{1'b0}};
            press_q   <= {N_CH{1'b0}};
            release_q <= {N_CH{1'b0}};
            repeat_q  <= {N_CH{1'b0}};
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
                rpt_q[ch]   <= rpt_d[ch];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    // Next state: count consecutive opposite samples, flip after DB_COUNT.
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            if (tick_s) begin
                case (state_q[ch])
                    ST_LOW: begin
                        if (s_s[ch]) begin
                            state_d[ch] = ST_PEND_HI;
                            cnt_d[ch]   = CNT_ONE;
                        end else begin
                            state_d[ch] = ST_LOW;
                            cnt_d[ch]   = CNT_ZERO;
                        end
                    end
                    ST_PEND_HI: begin
                        if (s_s[ch]) begin
                            if ((cnt_q[ch] + CNT_ONE) == CNT_LAST) begin
                                state_d[ch] = ST_HIGH;
                                cnt_d[ch]   = CNT_ZERO;
                            end else begin
                                state_d[ch] = ST_PEND_HI;
                                cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
                            end
                        end else begin
                            state_d[ch] = ST_LOW;
                            cnt_d[ch]   = CNT_ZERO;
                        end
                    end
                    ST_HIGH: begin
                        if (!s_s[ch]) begin
                            state_d[ch] = ST_PEND_LO;
                            cnt_d[ch]   = CNT_ONE;
                        end else begin
                            state_d[ch] = ST_HIGH;
                            cnt_d[ch]   = CNT_ZERO;
                        end
                    end
                    ST_PEND_LO: begin
                        if (!s_s[ch]) begin
                            if ((cnt_q[ch] + CNT_ONE) == CNT_LAST) begin
                                state_d[ch] = ST_LOW;
                                cnt_d[ch]   = CNT_ZERO;
                            end else begin
                                state_d[ch] = ST_PEND_LO;
                                cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
                            end
                        end else begin
                            state_d[ch] = ST_HIGH;
                            cnt_d[ch]   = CNT_ZERO;
                        end
                    end
                    default: begin
                        state_d[ch] = ST_LOW;
                        cnt_d[ch]   = CNT_ZERO;
                    end
                endcase
            end else begin
                state_d[ch] = state_q[ch];
                cnt_d[ch]   = cnt_q[ch];
            end
        end
    end

    // Outputs and repeat timer: the release transition wins over a repeat
    // in the same tick, and the press tick never advances the timer.
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            press_d[ch]   = 1'b0;
            release_d[ch] = 1'b0;
            repeat_d[ch]  = 1'b0;
            rpt_d[ch]     = rpt_q[ch];
            level_d[ch]   = (state_d[ch] == ST_HIGH) || (state_d[ch] == ST_PEND_LO);
            if (tick_s) begin
                if ((state_q[ch] == ST_PEND_HI) && (state_d[ch] == ST_HIGH)) begin
                    press_d[ch] = 1'b1;
                    rpt_d[ch]   = RPT_ZERO;
                end else if ((state_q[ch] == ST_PEND_LO) && (state_d[ch] == ST_LOW)) begin
                    release_d[ch] = 1'b1;
                    rpt_d[ch]     = RPT_ZERO;
                end else if ((state_q[ch] == ST_HIGH) || (state_q[ch] == ST_PEND_LO)) begin
                    if ((rpt_q[ch] + RPT_ONE) == RPT_FIRE) begin
                        repeat_d[ch] = REPEAT_EN;
                        rpt_d[ch]    = RPT_RELOAD;
                    end else begin
                        rpt_d[ch]    = rpt_q[ch] + RPT_ONE;
                    end
                end else begin
                    rpt_d[ch] = rpt_q[ch];
                end
            end else begin
                rpt_d[ch] = rpt_q[ch];
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_repeat  = repeat_q;
    assign bus.sample_tick = sample_tick_q;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Self-checking bench for paddle_input_conditioner. Two instances share the
// raw inputs: one with auto-repeat enabled, one with it disabled. Expected
// outputs come from a tick-level reference model: level flips after DB
// consecutive opposite samples; repeats fire at press+RD, +RR, ... ticks.
module tb_paddle_input_conditioner;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] raw;

    paddle_input_conditioner_if #(.N_CH(N)) bus1 ();
    paddle_input_conditioner_if #(.N_CH(N)) bus2 ();

    assign bus1.btn_raw = raw;
    assign bus2.btn_raw = raw;

    paddle_input_conditioner #(
        .N_CH(N), .SYNC_STAGES(SS), .TICK_DIV(TD), .DB_COUNT(DB),
        .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_dut (
        .ClkPort(clk), .Reset_n(rst_n), .bus(bus1)
    );

    paddle_input_conditioner #(
        .N_CH(N), .SYNC_STAGES(SS), .TICK_DIV(TD), .DB_COUNT(DB),
        .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_dut_norpt (
        .ClkPort(clk), .Reset_n(rst_n), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [N-1:0] m_sync [SS];
    int           m_cyc;
    logic [N-1:0] m_level;
    int           m_run  [N];
    int           m_hold [N];
    logic [N-1:0] m_press, m_rel, m_rpt;
    logic         m_tick;
    logic [16:0]  exp1, exp2;

    function automatic logic [16:0] act1();
        act1 = {bus1.btn_level, bus1.btn_press, bus1.btn_release, bus1.btn_repeat, bus1.sample_tick};
    endfunction

    function automatic logic [16:0] act2();
        act2 = {bus2.btn_level, bus2.btn_press, bus2.btn_release, bus2.btn_repeat, bus2.sample_tick};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_sync[i] = 4'b0000;
        m_cyc   = 0;
        m_level = 4'b0000;
        for (int c = 0; c < N; c++) begin
            m_run[c]  = 0;
            m_hold[c] = 0;
        end
        m_press = 4'b0000; m_rel = 4'b0000; m_rpt = 4'b0000; m_tick = 1'b0;
        exp1 = 17'd0; exp2 = 17'd0;
    endtask

    // Apply raw for one clock, predict the outputs after the edge, sample at +1.
    task automatic step(input logic [N-1:0] raw_v);
        logic [N-1:0] s;
        raw = raw_v;
        s = m_sync[SS-1];
        m_tick = ((m_cyc % TD) == (TD - 1));
        m_press = 4'b0000; m_rel = 4'b0000; m_rpt = 4'b0000;
        if (m_tick) begin
            for (int c = 0; c < N; c++) begin
                if (s[c] != m_level[c]) m_run[c]++;
                else m_run[c] = 0;
                if (m_run[c] == DB) begin
                    m_run[c]   = 0;
                    m_level[c] = ~m_level[c];
                    m_hold[c]  = 0;
                    if (m_level[c]) m_press[c] = 1'b1;
                    else            m_rel[c]   = 1'b1;
                end else if (m_level[c]) begin
                    m_hold[c]++;
                    if (m_hold[c] >= RD && ((m_hold[c] - RD) % RR) == 0) m_rpt[c] = 1'b1;
                end
            end
        end
        for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = raw_v;
        m_cyc++;
        exp1 = {m_level, m_press, m_rel, m_rpt, m_tick};
        exp2 = {m_level, m_press, m_rel, 4'b0000, m_tick};
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first_tick = -1;
        int ticks = 0;
        raw = 4'b0000;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (act1() !== 17'd0) begin bad++; $display("FAIL reset_outputs dut=%h exp=%h", act1(), 17'd0); end
        total++; if (act2() !== 17'd0) begin bad++; $display("FAIL reset_outputs_norpt dut=%h exp=%h", act2(), 17'd0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(4'b0000);
            total++; if (act1() !== exp1) begin bad++; $display("FAIL reset_idle cyc=%0d dut=%h exp=%h", m_cyc, act1(), exp1); end
            total++; if (act2() !== exp2) begin bad++; $display("FAIL reset_idle_norpt cyc=%0d dut=%h exp=%h", m_cyc, act2(), exp2); end
            if (bus1.sample_tick) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
        end
        // Seen after the 4th edge, i.e. in cycle 5 counting the release cycle as 1.
        total++; if (first_tick !== 4) begin bad++; $display("FAIL first_sample_tick edge=%0d exp=%0d", first_tick, 4); end
        total++; if (ticks !== 4) begin bad++; $display("FAIL sample_tick_count got=%0d exp=%0d", ticks, 4); end
    endtask

    task automatic test_clean_press();
        int idle, a, nsteps, press_at, last_rpt, npress, nrpt, exp_nrpt;
        idle = $urandom_range(0, 7);
        a = idle;
        nsteps = idle + 20 * TD + (DB + 3) * TD;
        press_at = -1; last_rpt = -1; npress = 0; nrpt = 0; exp_nrpt = 0;
        for (int n = 0; n < nsteps; n++) begin
            step((n >= a && n < a + 20 * TD) ? 4'b0001 : 4'b0000);
            total++; if (act1() !== exp1) begin bad++; $display("FAIL clean_press cyc=%0d dut=%h exp=%h", m_cyc, act1(), exp1); end
            total++; if (act2() !== exp2) begin bad++; $display("FAIL clean_press_norpt cyc=%0d dut=%h exp=%h", m_cyc, act2(), exp2); end
            if (m_rpt[0]) exp_nrpt++;
            if (bus1.btn_press[0]) begin
                npress++;
                press_at = n;
            end
            if (bus1.btn_repeat[0]) begin
                if (last_rpt < 0) begin
                    total++; if (n - press_at !== RD * TD) begin bad++; $display("FAIL first_repeat_gap got=%0d exp=%0d", n - press_at, RD * TD); end
                end else begin
                    total++; if (n - last_rpt !== RR * TD) begin bad++; $display("FAIL repeat_gap got=%0d exp=%0d", n - last_rpt, RR * TD); end
                end
                last_rpt = n;
                nrpt++;
            end
        end
        total++; if (npress !== 1) begin bad++; $display("FAIL clean_press_count got=%0d exp=%0d", npress, 1); end
        total++;
        if ((press_at - a + 1) < SS + TD * (DB - 1) + 1 || (press_at - a + 1) > SS + TD * DB + 1) begin
            bad++; $display("FAIL press_latency got=%0d exp=%0d..%0d", press_at - a + 1, SS + TD * (DB - 1) + 1, SS + TD * DB + 1);
        end
        total++; if (nrpt !== exp_nrpt || nrpt < 7) begin bad++; $display("FAIL repeat_count got=%0d exp=%0d", nrpt, exp_nrpt); end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int first_lvl, npress, nsteps;
        pat = 6'b111011;  // chunk k uses pat[k], chunk 0 first: 1,1,0,1,1,1
        first_lvl = -1; npress = 0;
        nsteps = 9 * TD + (DB + 3) * TD;
        for (int n = 0; n < nsteps; n++) begin
            int k;
            logic v;
            k = n / TD;
            if (k < 6) v = pat[k];
            else v = (k < 9) ? 1'b1 : 1'b0;
            step({2'b00, v, 1'b0});
            total++; if (act1() !== exp1) begin bad++; $display("FAIL bounce cyc=%0d dut=%h exp=%h", m_cyc, act1(), exp1); end
            total++; if (act2() !== exp2) begin bad++; $display("FAIL bounce_norpt cyc=%0d dut=%h exp=%h", m_cyc, act2(), exp2); end
            if (bus1.btn_press[1]) npress++;
            if (bus1.btn_level[1] && first_lvl < 0) first_lvl = n;
        end
        total++; if (npress !== 1) begin bad++; $display("FAIL bounce_press_count got=%0d exp=%0d", npress, 1); end
        total++;
        if (first_lvl < 5 * TD + SS || first_lvl > 6 * TD + SS) begin
            bad++; $display("FAIL bounce_level_step got=%0d exp=%0d..%0d", first_lvl, 5 * TD + SS, 6 * TD + SS);
        end
    endtask

    task automatic test_release();
        int npress, nrel, nrpt, nsteps;
        npress = 0; nrel = 0; nrpt = 0;
        nsteps = 3 * TD + (DB + 3) * TD;
        for (int n = 0; n < nsteps; n++) begin
            step((n < 3 * TD) ? 4'b0100 : 4'b0000);
            total++; if (act1() !== exp1) begin bad++; $display("FAIL release cyc=%0d dut=%h exp=%h", m_cyc, act1(), exp1); end
            total++; if (act2() !== exp2) begin bad++; $display("FAIL release_norpt cyc=%0d dut=%h exp=%h", m_cyc, act2(), exp2); end
            if (bus1.btn_press[2])   npress++;
            if (bus1.btn_release[2]) nrel++;
            if (bus1.btn_repeat[2])  nrpt++;
        end
        total++; if (npress !== 1) begin bad++; $display("FAIL release_press_count got=%0d exp=%0d", npress, 1); end
        total++; if (nrel !== 1) begin bad++; $display("FAIL release_count got=%0d exp=%0d", nrel, 1); end
        total++; if (nrpt !== 0) begin bad++; $display("FAIL release_repeat_count got=%0d exp=%0d", nrpt, 0); end
        total++; if (bus1.btn_level[2] !== 1'b0) begin bad++; $display("FAIL release_level got=%b exp=%b", bus1.btn_level[2], 1'b0); end
    endtask

    task automatic test_simultaneous();
        int both, npress_cyc, nrpt2;
        both = 0; npress_cyc = 0; nrpt2 = 0;
        for (int n = 0; n < 18 * TD; n++) begin
            step((n < 12 * TD) ? 4'b1001 : 4'b0000);
            total++; if (act1() !== exp1) begin bad++; $display("FAIL simul cyc=%0d dut=%h exp=%h", m_cyc, act1(), exp1); end
            total++; if (act2() !== exp2) begin bad++; $display("FAIL simul_norpt cyc=%0d dut=%h exp=%h", m_cyc, act2(), exp2); end
            if (bus1.btn_press !== 4'b0000) npress_cyc++;
            if (bus1.btn_press === 4'b1001) both++;
            if (bus2.btn_repeat !== 4'b0000) nrpt2++;
        end
        total++; if (both !== 1 || npress_cyc !== 1) begin bad++; $display("FAIL simul_press both=%0d cycles=%0d exp=1/1", both, npress_cyc); end
        total++; if (nrpt2 !== 0) begin bad++; $display("FAIL norpt_repeat got=%0d exp=%0d", nrpt2, 0); end
    endtask

    task automatic test_reset_mid_hold();
        int waited, npress;
        waited = 0; npress = 0;
        while (bus1.btn_level[1] !== 1'b1 && waited < 40) begin
            step(4'b0010);
            total++; if (act1() !== exp1) begin bad++; $display("FAIL hold cyc=%0d dut=%h exp=%h", m_cyc, act1(), exp1); end
            waited++;
        end
        total++; if (bus1.btn_level[1] !== 1'b1) begin bad++; $display("FAIL hold_timeout level=%b exp=%b", bus1.btn_level[1], 1'b1); end
        for (int n = 0; n < 2 * TD; n++) step(4'b0010);
        rst_n = 1'b0;
        #1;
        total++; if (act1() !== 17'd0) begin bad++; $display("FAIL async_reset dut=%h exp=%h", act1(), 17'd0); end
        total++; if (act2() !== 17'd0) begin bad++; $display("FAIL async_reset_norpt dut=%h exp=%h", act2(), 17'd0); end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            total++; if (bus1.btn_release !== 4'b0000 || bus1.btn_level !== 4'b0000) begin
                bad++; $display("FAIL reset_hold rel=%b lvl=%b exp=0000", bus1.btn_release, bus1.btn_level);
            end
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6 * TD; n++) begin
            step(4'b0010);
            total++; if (act1() !== exp1) begin bad++; $display("FAIL repress cyc=%0d dut=%h exp=%h", m_cyc, act1(), exp1); end
            total++; if (act2() !== exp2) begin bad++; $display("FAIL repress_norpt cyc=%0d dut=%h exp=%h", m_cyc, act2(), exp2); end
            if (bus1.btn_press[1]) npress++;
        end
        total++; if (npress !== 1) begin bad++; $display("FAIL repress_count got=%0d exp=%0d", npress, 1); end
        for (int n = 0; n < (DB + 3) * TD; n++) begin
            step(4'b0000);
            total++; if (act1() !== exp1) begin bad++; $display("FAIL repress_release cyc=%0d dut=%h exp=%h", m_cyc, act1(), exp1); end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        v = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) v[$urandom_range(0, N - 1)] ^= 1'b1;
            step(v);
            total++; if (act1() !== exp1) begin bad++; $display("FAIL random cyc=%0d dut=%h exp=%h", m_cyc, act1(), exp1); end
            total++; if (act2() !== exp2) begin bad++; $display("FAIL random_norpt cyc=%0d dut=%h exp=%h", m_cyc, act2(), exp2); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        raw   = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
